nvdla_glb_csb_intr_gen: RTL and testbench
=========================================

Name: nvdla_glb_csb_intr_gen

Overview:
Parametrised successor of the GLB CSB front end. It terminates the CSB request/response channel and owns a generated register file for NUM_CH done-interrupt sources: mask, software set, and write-1-to-clear status. It adds interrupt coalescing, so the core interrupt fires on a pending-count threshold or on a timeout, and it returns error responses for unmapped offsets. It sits between the CSB master and the per-unit done pulses (CDMA, CACC, SDP, PDP, CDP, ...).

Parameters:
NUM_CH, 12, number of done-interrupt channels; legal range 1..32.
HW_VER, 32'h0001_0001, value returned by the HW_VERSION register.
CNT_W, 16, width of the coalescing timeout counter and the timeout field.

Ports:
nvdla_core_clk  in  1  sole clock.
nvdla_core_rst  in  1  reset, synchronous, active-high.
csb2glb_req_pvld  in  1  request valid.
csb2glb_req_prdy  out  1  request ready; tied to 1 (one request per cycle).
csb2glb_req_pd  in  63  request payload: [21:0] addr (word), [53:22] wdat, [54] write, [55] nposted, [56] srcpriv (unused), [60:57] wrbe (unused), [62:61] level (unused).
glb2csb_resp_valid  out  1  response valid; valid-only, no backpressure.
glb2csb_resp_pd  out  34  response payload: [33] 0=read/1=write ack, [32] error, [31:0] rdata.
done_pulse  in  NUM_CH  one-cycle done event per channel.
done_mask  out  NUM_CH  current INTR_MASK.
done_status  out  NUM_CH  current INTR_STATUS.
core_intr  out  1  coalesced interrupt, level.

Behaviour:
- Clock and reset: one clock, nvdla_core_clk. Reset nvdla_core_rst is synchronous, active-high.
- Reset values:
  - resp_valid=0, resp_pd=0, core_intr=0, done_status=0.
  - done_mask = all ones (all channels masked).
  - COAL.thresh=1, COAL.timeout=0, timer=0.
- Request pipeline:
  - A request with pvld=1 in cycle T is registered at the end of T and decoded in T+1.
  - A write takes effect at the end of T+1.
  - The response is registered and valid in T+2 for exactly one cycle.
  - Back-to-back requests every cycle are supported.
  - A read returns the register value as it stands during T+1, before any same-cycle done_pulse update.
- Address decode: offset = {addr[9:0],2'b00}; addr[21:10] is ignored. wrbe is ignored (full-word writes).
- Register map:
  - 0x000 HW_VERSION: RO, returns HW_VER.
  - 0x004 INTR_MASK: RW, bits [NUM_CH-1:0]; upper bits read 0.
  - 0x008 INTR_SET: WO; writing 1 to bit i sets status[i]; reads return 0.
  - 0x00C INTR_STATUS: RO, write-1-to-clear.
  - 0x010 INTR_COAL: RW; [7:0] thresh, [CNT_W+15:16] timeout.
  - 0x014 INTR_PEND: RO; popcount(status & ~mask) in bits [5:0].
- Responses:
  - Read: [33]=0, data per the map.
  - Non-posted write: [33]=1, data 0.
  - Posted write: no response.
  - Unmapped offset (0x018..0xFFC), read: error=1, data 0.
  - Unmapped offset, non-posted write: error=1, no state change. Posted write to an unmapped offset is dropped silently.
- Status update per bit, each cycle: status_next = (status & ~w1c) | done_pulse | set_wr. Set beats clear when both hit the same bit in the same cycle.
- Masking: the mask gates only core_intr and PEND, never status capture.
- Coalescing:
  - pend = popcount(status & ~mask); eff_thresh = max(thresh,1).
  - Timer:
    - Clears to 0 when pend==0 or core_intr==1.
    - Otherwise increments each cycle, saturating at all ones.
  - core_intr rises the cycle after either:
    - pend >= eff_thresh, or
    - timeout != 0 and timer == timeout-1 with pend > 0.
  - core_intr stays high until pend becomes 0 (cleared or masked), then drops the next cycle.
- Timing of mask/COAL writes: they affect pend and the comparison from the cycle after the write.
- Reset mid-operation: drops any in-flight request. No response is issued for it.

Test Plan:
- Reset, then read 0x000, 0x004, 0x010 → resp data 32'h00010001, 32'h00000FFF, 32'h00000001. Each response valid exactly 2 cycles after pvld, with [33]=0 and error=0.
- Write 0x004=0 (nposted=1); pulse done_pulse[3] → status read = 0x8; core_intr=1 on the cycle after the status update. Write 0x00C=0x8 → core_intr drops the following cycle; write ack [33]=1.
- COAL thresh=3, timeout=0, mask=0; pulse channels 0, 1, 2 on separate cycles → core_intr stays low after two pulses and rises only after the third; PEND reads 3.
- COAL thresh=8, timeout=10, mask=0; single pulse on ch5 → core_intr rises exactly 10 cycles after status[5] sets.
- Same cycle: done_pulse[2]=1 and W1C write of bit 2 → status[2] remains 1. Read of offset 0x020 → error=1, data 0. Posted write to 0x020 → no response, no state change.
- Back-to-back reads on 4 consecutive cycles → 4 consecutive responses with no gaps, in order. Assert reset in the cycle after a read is accepted → no response is issued.

Source files
------------

// File: rtl/nvdla_glb_csb_intr_gen.sv
// CSB front end for the global interrupt block: register file for NUM_CH
// done sources (mask / set / W1C status) plus count/timeout interrupt coalescing.
module nvdla_glb_csb_intr_gen #(
  parameter int          NUM_CH = 12,
  parameter logic [31:0] HW_VER = 32'h0001_0001,
  parameter int          CNT_W  = 16
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic              csb2glb_req_pvld,
  output logic              csb2glb_req_prdy,
  input  logic [62:0]       csb2glb_req_pd,
  output logic              glb2csb_resp_valid,
  output logic [33:0]       glb2csb_resp_pd,
  input  logic [NUM_CH-1:0] done_pulse,
  output logic [NUM_CH-1:0] done_mask,
  output logic [NUM_CH-1:0] done_status,
  output logic              core_intr
);

  typedef struct packed {
    logic        nposted;
    logic        write;
    logic [31:0] wdat;
    logic [9:0]  addr;
  } req_t;

  localparam logic [9:0] A_VER  = 10'h000;
  localparam logic [9:0] A_MASK = 10'h001;
  localparam logic [9:0] A_SET  = 10'h002;
  localparam logic [9:0] A_STAT = 10'h003;
  localparam logic [9:0] A_COAL = 10'h004;
  localparam logic [9:0] A_PEND = 10'h005;

  logic              req_vld_q, req_vld_d;
  req_t              req_q, req_d;
  logic              resp_valid_q, resp_valid_d;
  logic [33:0]       resp_pd_q, resp_pd_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] status_q, status_d;
  logic [7:0]        thresh_q, thresh_d;
  logic [CNT_W-1:0]  timeout_q, timeout_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic              intr_q, intr_d;

  logic [NUM_CH-1:0] set_wr, w1c;
  logic [31:0]       rd_data;
  logic              mapped, wr_en;
  logic [5:0]        pend;
  logic [7:0]        eff_thresh;
  logic              unused_req;

  // srcpriv, wrbe, level and the upper address bits carry no meaning here
  assign unused_req = ^{csb2glb_req_pd[62:56], csb2glb_req_pd[21:10]};

  assign csb2glb_req_prdy   = 1'b1;
  assign glb2csb_resp_valid = resp_valid_q;
  assign glb2csb_resp_pd    = resp_pd_q;
  assign done_mask          = mask_q;
  assign done_status        = status_q;
  assign core_intr          = intr_q;

  always_comb begin
    req_vld_d       = csb2glb_req_pvld;
    req_d.addr      = csb2glb_req_pd[9:0];
    req_d.wdat      = csb2glb_req_pd[53:22];
    req_d.write     = csb2glb_req_pd[54];
    req_d.nposted   = csb2glb_req_pd[55];
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < NUM_CH; i++)
      pend = pend + {5'b0, status_q[i] & ~mask_q[i]};
    eff_thresh = (thresh_q == 8'd0) ? 8'd1 : thresh_q;
  end

  // decode stage: reads see registers as they stand this cycle
  always_comb begin
    mapped    = (req_q.addr <= A_PEND);
    wr_en     = req_vld_q & req_q.write & mapped;
    rd_data   = '0;
    mask_d    = mask_q;
    thresh_d  = thresh_q;
    timeout_d = timeout_q;
    set_wr    = '0;
    w1c       = '0;
    case (req_q.addr)
      A_VER:  rd_data = HW_VER;
      A_MASK: rd_data[NUM_CH-1:0] = mask_q;
      A_STAT: rd_data[NUM_CH-1:0] = status_q;
      A_COAL: begin
        rd_data[7:0]        = thresh_q;
        rd_data[CNT_W+15:16] = timeout_q;
      end
      A_PEND: rd_data[5:0] = pend;
      default: rd_data = '0;
    endcase
    if (wr_en) begin
      case (req_q.addr)
        A_MASK: mask_d = req_q.wdat[NUM_CH-1:0];
        A_SET:  set_wr = req_q.wdat[NUM_CH-1:0];
        A_STAT: w1c    = req_q.wdat[NUM_CH-1:0];
        A_COAL: begin
          thresh_d  = req_q.wdat[7:0];
          timeout_d = req_q.wdat[CNT_W+15:16];
        end
        default: ;
      endcase
    end
    resp_valid_d = req_vld_q & (~req_q.write | req_q.nposted);
    resp_pd_d    = {req_q.write, ~mapped,
                    (req_q.write | ~mapped) ? 32'h0 : rd_data};
  end

  // set beats clear on the same bit
  always_comb begin
    status_d = (status_q & ~w1c) | done_pulse | set_wr;
  end

  always_comb begin
    timer_d = timer_q;
    if (pend == 6'd0 || intr_q)  timer_d = '0;
    else if (timer_q != '1)      timer_d = timer_q + CNT_W'(1);
    if (intr_q)
      intr_d = (pend != 6'd0);
    else
      intr_d = ({2'b0, pend} >= eff_thresh) ||
               ((timeout_q != '0) && (pend != 6'd0) &&
                (timer_q == timeout_q - CNT_W'(1)));
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      req_vld_q    <= 1'b0;
      req_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_pd_q    <= '0;
      mask_q       <= '1;
      status_q     <= '0;
      thresh_q     <= 8'd1;
      timeout_q    <= '0;
      timer_q      <= '0;
      intr_q       <= 1'b0;
    end else begin
      req_vld_q    <= req_vld_d;
      req_q        <= req_d;
      resp_valid_q <= resp_valid_d;
      resp_pd_q    <= resp_pd_d;
      mask_q       <= mask_d;
      status_q     <= status_d;
      thresh_q     <= thresh_d;
      timeout_q    <= timeout_d;
      timer_q      <= timer_d;
      intr_q       <= intr_d;
    end
  end

endmodule

// File: tb/tb_nvdla_glb_csb_intr_gen.sv
// Directed bench for nvdla_glb_csb_intr_gen: register access, W1C/set race,
// coalescing by count and timeout, error responses, pipelining and reset drop.
module tb_nvdla_glb_csb_intr_gen;
  localparam int NUM_CH = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              pvld;
  logic              prdy;
  logic [62:0]       req_pd;
  logic              resp_valid;
  logic [33:0]       resp_pd;
  logic [NUM_CH-1:0] done_pulse;
  logic [NUM_CH-1:0] done_mask;
  logic [NUM_CH-1:0] done_status;
  logic              core_intr;

  int total = 0;
  int bad   = 0;

  nvdla_glb_csb_intr_gen #(.NUM_CH(NUM_CH)) dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rst    (rst),
    .csb2glb_req_pvld  (pvld),
    .csb2glb_req_prdy  (prdy),
    .csb2glb_req_pd    (req_pd),
    .glb2csb_resp_valid(resp_valid),
    .glb2csb_resp_pd   (resp_pd),
    .done_pulse        (done_pulse),
    .done_mask         (done_mask),
    .done_status       (done_status),
    .core_intr         (core_intr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [62:0] mk_pd(input logic [11:0] off, input logic [31:0] wd,
                                        input logic wr, input logic np);
    logic [21:0] a;
    a = {10'h3A5, off[11:2]};  // junk in ignored upper address bits
    return {2'b11, 4'hF, 1'b0, np, wr, wd, a};
  endfunction

  // leaves the caller in the decode cycle (T+1)
  task automatic issue(input logic [11:0] off, input logic [31:0] wd, input logic wr, input logic np);
    pvld = 1'b1; req_pd = mk_pd(off, wd, wr, np);
    tick();
    pvld = 1'b0; req_pd = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] off, input logic [33:0] exp_pd);
    issue(off, 32'h0, 1'b0, 1'b0);
    chk({tag, "_early"}, resp_valid, 1'b0);
    tick();
    chk({tag, "_vld"}, resp_valid, 1'b1);
    chk(tag, resp_pd, exp_pd);
    tick();
    chk({tag, "_once"}, resp_valid, 1'b0);
  endtask

  task automatic wr_np(input string tag, input logic [11:0] off, input logic [31:0] wd,
                       input logic [33:0] exp_pd);
    issue(off, wd, 1'b1, 1'b1);
    tick();
    chk({tag, "_vld"}, resp_valid, 1'b1);
    chk(tag, resp_pd, exp_pd);
    tick();
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] p);
    done_pulse = p;
    tick();
    done_pulse = '0;
  endtask

  localparam logic [33:0] ACK = 34'h2_0000_0000;

  initial begin
    logic [11:0] offs [4];
    logic [33:0] exps [4];
    rst = 1'b1; pvld = 1'b0; req_pd = '0; done_pulse = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    chk("rst_resp_vld", resp_valid, 1'b0);
    chk("rst_resp_pd", resp_pd, 34'h0);
    chk("rst_intr", core_intr, 1'b0);
    chk("rst_status", done_status, 12'h000);
    chk("rst_mask", done_mask, 12'hFFF);

    rd_chk("rd_ver", 12'h000, 34'h0_0001_0001);
    rd_chk("rd_mask", 12'h004, 34'h0_0000_0FFF);
    rd_chk("rd_coal", 12'h010, 34'h0_0000_0001);

    // unmask, single done on ch3, clear via W1C
    wr_np("wr_mask0", 12'h004, 32'h0, ACK);
    chk("mask0", done_mask, 12'h000);
    pulse(12'h008);
    chk("st3", done_status, 12'h008);
    chk("intr_not_yet", core_intr, 1'b0);
    tick();
    chk("intr_ch3", core_intr, 1'b1);
    rd_chk("rd_st3", 12'h00C, 34'h0_0000_0008);
    wr_np("w1c_ch3", 12'h00C, 32'h8, ACK);
    chk("intr_drop", core_intr, 1'b0);
    chk("st_clr", done_status, 12'h000);

    // count coalescing, thresh=3
    wr_np("wr_coal3", 12'h010, 32'h0000_0003, ACK);
    pulse(12'h001); tick();
    pulse(12'h002); tick(); tick();
    chk("thr_2pulse", core_intr, 1'b0);
    pulse(12'h004);
    chk("thr_3_lat", core_intr, 1'b0);
    tick();
    chk("thr_3pulse", core_intr, 1'b1);
    rd_chk("rd_pend3", 12'h014, 34'h0_0000_0003);
    wr_np("w1c_7", 12'h00C, 32'h7, ACK);
    chk("thr_drop", core_intr, 1'b0);

    // timeout coalescing, thresh=8 timeout=10
    wr_np("wr_coal_to", 12'h010, 32'h000A_0008, ACK);
    rd_chk("rd_coal_to", 12'h010, 34'h0_000A_0008);
    tick(); tick();
    pulse(12'h020);
    chk("to_st5", done_status, 12'h020);
    for (int k = 1; k < 10; k++) begin
      chk($sformatf("to_low%0d", k), core_intr, 1'b0);
      tick();
    end
    chk("to_low_last", core_intr, 1'b0);
    tick();
    chk("to_fire", core_intr, 1'b1);
    wr_np("w1c_20", 12'h00C, 32'h20, ACK);
    chk("to_drop", core_intr, 1'b0);
    wr_np("wr_coal1", 12'h010, 32'h0000_0001, ACK);

    // done pulse and W1C of the same bit in the same cycle
    issue(12'h00C, 32'h4, 1'b1, 1'b1);
    done_pulse = 12'h004;
    tick();
    done_pulse = '0;
    chk("race_ack", resp_pd, ACK);
    chk("race_st2", done_status, 12'h004);
    tick();

    // unmapped accesses
    rd_chk("rd_unmap", 12'h020, 34'h1_0000_0000);
    wr_np("wr_unmap", 12'h020, 32'hFFFF_FFFF, 34'h3_0000_0000);
    issue(12'h020, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    chk("posted_unmap_noresp", resp_valid, 1'b0);
    tick();
    chk("unmap_mask", done_mask, 12'h000);
    chk("unmap_st", done_status, 12'h004);

    // four back-to-back reads
    offs = '{12'h000, 12'h004, 12'h00C, 12'h014};
    exps = '{34'h0_0001_0001, 34'h0, 34'h0_0000_0004, 34'h0_0000_0001};
    for (int c = 0; c < 6; c++) begin
      if (c >= 2) begin
        chk($sformatf("b2b_vld%0d", c - 2), resp_valid, 1'b1);
        chk($sformatf("b2b_pd%0d", c - 2), resp_pd, exps[c-2]);
      end else begin
        chk($sformatf("b2b_idle%0d", c), resp_valid, 1'b0);
      end
      if (c < 4) begin
        pvld = 1'b1; req_pd = mk_pd(offs[c], 32'h0, 1'b0, 1'b0);
      end else begin
        pvld = 1'b0; req_pd = '0;
      end
      tick();
    end
    chk("b2b_end", resp_valid, 1'b0);

    // reset right after a read is accepted drops its response
    issue(12'h000, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_drop_t2", resp_valid, 1'b0);
    tick();
    chk("rst_drop_t3", resp_valid, 1'b0);
    chk("rst2_mask", done_mask, 12'hFFF);
    chk("rst2_status", done_status, 12'h000);
    chk("rst2_intr", core_intr, 1'b0);
    chk("prdy", prdy, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
